demux_1_4_stream: RTL



---
 rtl/demux_1_4_stream.sv | 92 +++++++++
 1 files changed

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Optional feature: define DEMUX_ROUND_ROBIN_EN to steer words in fixed rotating order instead of by in_sel.
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  // Handshake: a word moves on any cycle where valid and ready are both high;
  // ready never looks at valid, and a held word stays stable until it moves.

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } chan_state_e;

  // Per-channel state is visible on out_valid (FULL <=> out_valid[k]).
  chan_state_e      state_q [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [1:0]       dst;
  logic             accept;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_ptr_d;
  logic       unused_sel;

  assign unused_sel = ^in_sel;
  assign dst        = rr_ptr_q;
  assign rr_ptr_d   = accept ? rr_ptr_q + 2'd1 : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign dst = in_sel;
`endif

  // A full channel can still take a word in the same cycle its consumer drains it.
  assign in_ready = !rst && ((state_q[dst] == CH_EMPTY) || out_ready[dst]);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= CH_EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (dst == 2'(k))) begin
          state_q[k] <= CH_FULL;
          data_q[k]  <= in_data;
        end else begin
          case (state_q[k])
            CH_EMPTY: state_q[k] <= CH_EMPTY;
            CH_FULL:  state_q[k] <= out_ready[k] ? CH_EMPTY : CH_FULL;
            default:  state_q[k] <= CH_EMPTY;
          endcase
        end
      end
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (state_q[k] == CH_FULL);
    end
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

endmodule
